// File: rtl/calc_result_bcd.sv
// Signed/unsigned binary to packed BCD converter (iterative double-dabble, one bit per clock).
// Optional leading-zero blanking is enabled by defining BCD_LEADING_BLANK_EN.
module calc_result_bcd #(
  parameter int N      = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N-1:0]        bin_in,
  output logic                in_ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                sign_out,
  output logic                ovf_out,
  output logic                out_valid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  scratch;
  logic [N-1:0]  mag;
  logic          sign_r;
  logic          ovf_r;

  logic [N-1:0]  load_mag;
  logic          load_sign;
  logic [W-1:0]  adj;
  logic [W-1:0]  final_bcd;
  logic          lead;

  // Negating the most negative value wraps back to 2^(N-1), which is the correct magnitude.
  always_comb begin
    load_mag  = bin_in;
    load_sign = 1'b0;
    if (SIGNED != 0 && bin_in[N-1]) begin
      load_mag  = ~bin_in + {{(N-1){1'b0}}, 1'b1};
      load_sign = 1'b1;
    end
  end

  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin
    final_bcd = scratch;
    lead      = 1'b1;
`ifdef BCD_LEADING_BLANK_EN
    // Digit 0 is excluded so a zero result still shows a single 0.
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (lead && scratch[4*d +: 4] == 4'd0)
        final_bcd[4*d +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      scratch   <= '0;
      mag       <= '0;
      sign_r    <= 1'b0;
      ovf_r     <= 1'b0;
      bcd_out   <= '0;
      sign_out  <= 1'b0;
      ovf_out   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag      <= load_mag;
            sign_r   <= load_sign;
            scratch  <= '0;
            ovf_r    <= 1'b0;
            cnt      <= CW'(N);
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // A carry out of the top digit means the value does not fit; keep it sticky.
          scratch <= {adj[W-2:0], mag[N-1]};
          mag     <= {mag[N-2:0], 1'b0};
          ovf_r   <= ovf_r | adj[W-1];
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= DONE;
        end
        DONE: begin
          bcd_out   <= final_bcd;
          sign_out  <= sign_r;
          ovf_out   <= ovf_r;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_result_bcd.sv
// Directed self-checking bench for calc_result_bcd: signed, unsigned and 2-digit instances share inputs.
// Expected values follow BCD_LEADING_BLANK_EN when it is defined.
module tb_calc_result_bcd;

`ifdef BCD_LEADING_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;

  logic        in_ready, sign_out, ovf_out, out_valid;
  logic [11:0] bcd_out;
  logic        u_in_ready, u_sign_out, u_ovf_out, u_out_valid;
  logic [11:0] u_bcd_out;
  logic        o_in_ready, o_sign_out, o_ovf_out, o_out_valid;
  logic [7:0]  o_bcd_out;

  int checks = 0;
  int errors = 0;
  int lat, low, cnt_valid, first_v, second_v;
  logic [11:0] cap_bcd;

  calc_result_bcd #(.N(8), .DIGITS(3), .SIGNED(1)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .in_ready(in_ready),
    .bcd_out(bcd_out), .sign_out(sign_out), .ovf_out(ovf_out), .out_valid(out_valid)
  );

  calc_result_bcd #(.N(8), .DIGITS(3), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .in_ready(u_in_ready),
    .bcd_out(u_bcd_out), .sign_out(u_sign_out), .ovf_out(u_ovf_out), .out_valid(u_out_valid)
  );

  calc_result_bcd #(.N(8), .DIGITS(2), .SIGNED(0)) dut_o (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .in_ready(o_in_ready),
    .bcd_out(o_bcd_out), .sign_out(o_sign_out), .ovf_out(o_ovf_out), .out_valid(o_out_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One conversion: pulse start, then count clocks until out_valid and how many samples saw in_ready low.
  task automatic applyStimulus(input logic [7:0] value, output int latency, output int low_cnt);
    bin_in = value;
    start  = 1'b1;
    tick();
    start   = 1'b0;
    bin_in  = ~value;
    latency = 0;
    low_cnt = 0;
    while (out_valid !== 1'b1 && latency < 40) begin
      if (in_ready === 1'b0) low_cnt++;
      tick();
      latency++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 8'h00;
    tick();
    tick();
    checkOutput("reset_bcd", {20'h0, bcd_out}, 32'h0);
    checkOutput("reset_sign", {31'h0, sign_out}, 32'h0);
    checkOutput("reset_ovf", {31'h0, ovf_out}, 32'h0);
    checkOutput("reset_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_ready", {31'h0, in_ready}, 32'h1);
    rst = 1'b0;
    tick();

    applyStimulus(8'h7F, lat, low);
    checkOutput("7f_latency", lat, 9);
    checkOutput("7f_ready_low", low, 9);
    checkOutput("7f_ready_back", {31'h0, in_ready}, 32'h1);
    checkOutput("7f_bcd", {20'h0, bcd_out}, 32'h127);
    checkOutput("7f_sign", {31'h0, sign_out}, 32'h0);
    checkOutput("7f_ovf", {31'h0, ovf_out}, 32'h0);
    checkOutput("7f_u_bcd", {20'h0, u_bcd_out}, 32'h127);
    tick();
    checkOutput("7f_valid_pulse", {31'h0, out_valid}, 32'h0);
    checkOutput("7f_hold", {20'h0, bcd_out}, 32'h127);

    applyStimulus(8'h80, lat, low);
    checkOutput("80_bcd", {20'h0, bcd_out}, 32'h128);
    checkOutput("80_sign", {31'h0, sign_out}, 32'h1);
    checkOutput("80_ovf", {31'h0, ovf_out}, 32'h0);
    checkOutput("80_u_bcd", {20'h0, u_bcd_out}, 32'h128);
    tick();

    applyStimulus(8'hFF, lat, low);
    checkOutput("ff_bcd", {20'h0, bcd_out}, BLANK ? 32'hFF1 : 32'h001);
    checkOutput("ff_sign", {31'h0, sign_out}, 32'h1);
    checkOutput("ff_u_bcd", {20'h0, u_bcd_out}, 32'h255);
    checkOutput("ff_u_sign", {31'h0, u_sign_out}, 32'h0);
    checkOutput("ff_o_ovf", {31'h0, o_ovf_out}, 32'h1);
    tick();

    applyStimulus(8'h00, lat, low);
    checkOutput("00_bcd", {20'h0, bcd_out}, BLANK ? 32'hFF0 : 32'h000);
    checkOutput("00_sign", {31'h0, sign_out}, 32'h0);
    checkOutput("00_o_ovf", {31'h0, o_ovf_out}, 32'h0);
    tick();

    applyStimulus(8'hC8, lat, low);
    checkOutput("c8_bcd", {20'h0, bcd_out}, BLANK ? 32'hF56 : 32'h056);
    checkOutput("c8_sign", {31'h0, sign_out}, 32'h1);
    checkOutput("c8_u_bcd", {20'h0, u_bcd_out}, 32'h200);
    checkOutput("c8_o_ovf", {31'h0, o_ovf_out}, 32'h1);
    checkOutput("c8_o_bcd", {24'h0, o_bcd_out}, BLANK ? 32'hF0 : 32'h00);
    tick();

    // Second start during a conversion must be dropped, not queued.
    bin_in = 8'h12;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    bin_in = 8'h63;
    start  = 1'b1;
    tick();
    start     = 1'b0;
    cnt_valid = 0;
    cap_bcd   = 12'h000;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        cnt_valid++;
        cap_bcd = bcd_out;
      end
    end
    checkOutput("ignore_count", cnt_valid, 1);
    checkOutput("ignore_bcd", {20'h0, cap_bcd}, BLANK ? 32'hF18 : 32'h018);

    bin_in   = 8'h21;
    start    = 1'b1;
    first_v  = -1;
    second_v = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        if (first_v < 0) first_v = i;
        else if (second_v < 0) second_v = i;
      end
    end
    start = 1'b0;
    checkOutput("b2b_first", first_v, 9);
    checkOutput("b2b_spacing", second_v - first_v, 10);
    checkOutput("b2b_bcd", {20'h0, bcd_out}, BLANK ? 32'hF33 : 32'h033);
    repeat (12) tick();

    // Asynchronous abort in the middle of a conversion.
    bin_in = 8'h7F;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_bcd", {20'h0, bcd_out}, 32'h0);
    checkOutput("abort_sign", {31'h0, sign_out}, 32'h0);
    checkOutput("abort_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("abort_ready", {31'h0, in_ready}, 32'h1);
    tick();
    rst       = 1'b0;
    cnt_valid = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) cnt_valid++;
    end
    checkOutput("abort_no_valid", cnt_valid, 0);
    applyStimulus(8'h2A, lat, low);
    checkOutput("post_abort_lat", lat, 9);
    checkOutput("post_abort_bcd", {20'h0, bcd_out}, BLANK ? 32'hF42 : 32'h042);
    tick();

    applyStimulus(8'h05, lat, low);
    checkOutput("05_bcd", {20'h0, bcd_out}, BLANK ? 32'hFF5 : 32'h005);
    tick();
    applyStimulus(8'hF6, lat, low);
    checkOutput("f6_bcd", {20'h0, bcd_out}, BLANK ? 32'hF10 : 32'h010);
    checkOutput("f6_sign", {31'h0, sign_out}, 32'h1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_result_bcd.md
Name: calc_result_bcd

Overview:
- Downstream stage of the calculator's N-bit carry-lookahead add/subtract unit.
- Captures the adder's two's-complement Sum and converts it to sign plus packed BCD digits for the display driver.
- Conversion is iterative double-dabble (add-3 / shift-left), one bit per clock, under a start/ready/valid handshake.

Parameters:
- N, 8: width of the binary input; matches the adder width.
- DIGITS, 3: number of BCD output digits; must satisfy 10^DIGITS >= 2^N.
- SIGNED, 1: 1 treats the input as two's complement (sign plus magnitude out); 0 treats it as unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request conversion of bin_in; accepted only when in_ready=1.
- bin_in  input  N  adder Sum; sampled on the accepting edge only.
- in_ready  output  1  high when idle and able to accept start.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 (ones) in bits [3:0].
- sign_out  output  1  1 = negative result; always 0 when SIGNED=0.
- ovf_out  output  1  result exceeded DIGITS capacity.
- out_valid  output  1  one-cycle pulse when bcd_out/sign_out/ovf_out update.

Behaviour:
- Reset (async, any state): FSM to IDLE; shift counter 0; scratch registers 0; bcd_out 0; sign_out 0; ovf_out 0; out_valid 0; in_ready 1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - start=1 at edge k: latch sign and magnitude, clear the BCD scratch, load counter=N, go to SHIFT.
  - Sign: SIGNED=1 gives sign=bin_in[N-1] and magnitude=|bin_in| as N-bit unsigned, so the most negative value maps to 2^(N-1) with no overflow. SIGNED=0 gives sign=0 and magnitude=bin_in.
- SHIFT, edges k+1..k+N:
  - Each scratch digit >=5 gets +3 first.
  - Then {scratch, magnitude} shifts left by 1.
  - A 1 shifted out of the top digit sets a sticky ovf flag.
  - Counter decrements; after the Nth shift, go to DONE.
- DONE, edge k+N+1: copy scratch to bcd_out, sign to sign_out, sticky ovf to ovf_out; pulse out_valid; return to IDLE.
- Timing:
  - in_ready=0 from after edge k until after edge k+N+1.
  - out_valid is high for exactly the cycle following edge k+N+1.
  - Total latency is N+1 clocks from accept to valid.
- Outputs hold their last result until the next DONE; they never show intermediate scratch values.
- start while in_ready=0 is ignored, not queued. bin_in changes during conversion have no effect.
- start held high continuously: a new conversion is accepted in the IDLE cycle after each DONE, giving a throughput of one result per N+2 cycles.
- Reset asserted mid-conversion aborts the conversion; outputs return to their reset values and there is no out_valid pulse.
- Negative zero cannot occur: magnitude 0 always gives sign_out=0.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- Defined:
  - At DONE, every leading zero digit above the most significant nonzero digit is replaced with 4'hF (blank code for the seven-segment decoder).
  - Digit 0 is never blanked, so value 0 shows as ...FF0.
  - sign_out is unaffected.
- Undefined: all digits are output as plain BCD, including leading zeros.

Test Plan:
- N=8, SIGNED=1, bin_in=8'h7F, start pulse -> in_ready low for 9 cycles; out_valid 9 clocks after accept; bcd_out=12'h127, sign_out=0, ovf_out=0.
- bin_in=8'h80 -> bcd_out=12'h128, sign_out=1. bin_in=8'hFF -> bcd_out=12'h001, sign_out=1. bin_in=8'h00 -> bcd_out=12'h000, sign_out=0.
- SIGNED=0, bin_in=8'hFF -> bcd_out=12'h255, sign_out=0. With DIGITS=2, bin_in=8'hC8 (200) -> ovf_out=1.
- Accept 8'h12 (18); pulse start with 8'h63 on cycle 3 of the conversion -> ignored; exactly one out_valid with bcd_out=12'h018. Then hold start high -> back-to-back results spaced 10 cycles apart.
- Assert rst on cycle 4 of a conversion of 8'h7F -> all outputs 0 immediately (asynchronous), no out_valid pulse; the next start converts normally.
- BCD_LEADING_BLANK_EN defined: 8'h05 -> bcd_out=12'hFF5; 8'h00 -> 12'hFF0; 8'hF6 (-10) -> 12'hF10, sign_out=1.
